serial_add_requester: RTL and testbench
=======================================

Name: serial_add_requester

Overview:
- Initiator side of the bit-serial adder operand/result interface.
- Buffers operand pairs pushed by upstream logic in a small FIFO and issues them one at a time to the adder's valid/ready input.
- Captures each result from the adder's valid_out, checks it against the expected sum, and forwards it downstream.
- Flags mismatches and watchdog timeouts; drives the adder in system-level tests and in integration.

Parameters:
- WIDTH, 4, operand and result width in bits.
- DEPTH, 4, operand FIFO entries; power of two, at least 2.
- TIMEOUT, 32, maximum cycles from issue handshake to result before timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- push_valid  input  1  upstream offers an operand pair.
- push_a  input  WIDTH  operand A.
- push_b  input  WIDTH  operand B.
- push_ready  output  1  FIFO not full.
- add_valid  output  1  to adder valid_in.
- add_a  output  WIDTH  to adder in_a.
- add_b  output  WIDTH  to adder in_b.
- add_ready  input  1  from adder ready_out.
- add_y  input  WIDTH  from adder y_out.
- add_y_valid  input  1  from adder valid_out.
- res_valid  output  1  one-cycle result strobe.
- res_y  output  WIDTH  captured result.
- res_err  output  1  qualified by res_valid; result is not equal to (a+b) mod 2^WIDTH.
- timeout_err  output  1  sticky watchdog flag.
- busy  output  1  FIFO non-empty or an operation is in flight.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - All outputs 0, except push_ready=1.
  - FIFO empty, state IDLE, watchdog counter 0.
- Reset mid-operation discards FIFO contents and the in-flight pair. Any later add_y_valid with no operation in flight is ignored.
- Push: accepted when push_valid && push_ready. The entry is visible to the issue logic the next cycle.
- FIFO full: push_ready=0 and push is ignored.
- Simultaneous push and pop when full: push is still refused, since push_ready is registered/derived from the current count.
- Simultaneous push and pop when empty: not possible; pop requires non-empty.
- Pointers wrap modulo DEPTH. fifo_count reflects push and pop in the same cycle as net zero.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE -> ISSUE when the FIFO is non-empty.
  - The head entry is popped into the in-flight registers exp_a/exp_b.
  - add_a/add_b are driven from these registers, and add_valid=1 from the next cycle.
- ISSUE:
  - add_valid stays high and add_a/add_b stay stable until add_valid && add_ready on a rising edge.
  - On the handshake: add_valid drops the following cycle and the FSM goes to WAIT, watchdog=0.
  - No combinational path from add_ready to add_valid.
- WAIT:
  - The watchdog increments each cycle.
  - On add_y_valid: res_valid=1 for exactly one cycle (registered, one cycle after add_y_valid), with res_y=add_y and res_err=(add_y != exp_a+exp_b truncated to WIDTH).
  - Then next state is ISSUE if the FIFO is non-empty (new pop the same cycle), else IDLE.
  - If the watchdog reaches TIMEOUT with no add_y_valid: timeout_err=1 (sticky until reset), no res_valid, and the FSM returns to IDLE. The pair is dropped.
- add_y_valid outside WAIT is ignored, with no res_valid.
- Arithmetic: the sum wraps modulo 2^WIDTH; no carry out is produced or checked. Example: 0xA+0x8 is expected to give 0x2.
- busy = (fifo_count != 0) || state != IDLE.
- Only one operation is ever outstanding.

Decomposition:
- Shared package serial_add_pkg:
  - state enum typedef (IDLE, ISSUE, WAIT).
  - WIDTH default constant.
  - operand-pair struct typedef {a, b}.
- Sub-module: sync_fifo, a parameterised single-clock FIFO holding the operand-pair struct, with push/pop/full/empty/count. It is reusable by other serial-arithmetic blocks.

Test Plan:
- Single pair: push A=0xA, B=0x4 with the adder model returning 0xE → exactly one res_valid with res_y=0xE, res_err=0; busy falls to 0 afterwards.
- Back-to-back and wrap:
  - Push {0xA,0x4}, {0x2,0x8}, {0xF,0x1} in consecutive cycles.
  - Expect results 0xE, 0xA, 0x0 in order; no overlap, since add_valid is never high in WAIT.
- Backpressure:
  - Adder holds add_ready=0 for 10 cycles.
  - add_valid stays high with add_a/add_b stable; the handshake occurs on the first add_ready=1 edge.
- FIFO full:
  - With add_ready=0, push DEPTH+2 pairs.
  - Expect push_ready=0 after DEPTH accepts, fifo_count=DEPTH, and the extra pairs are never issued.
- Error and timeout:
  - The adder model returns 0x7 for {0x3,0x3} → res_err=1.
  - Next, the model never asserts valid_out → timeout_err=1 after TIMEOUT cycles, the FSM reaches IDLE, and the next queued pair is issued.
- Reset mid-WAIT: assert rst_n=0 with 2 entries queued → all outputs reset immediately, fifo_count=0, and a late add_y_valid produces no res_valid.

Source files
------------

// File: rtl/serial_add_pkg.sv
// serial_add_pkg
// Shared definitions for the bit-serial adder requester slice.
//   WIDTH_DEFAULT  : default operand/result width in bits
//   req_state_t    : requester FSM states (IDLE, ISSUE, WAIT)
//   operand_pair_t : one {a, b} operand pair at the default width
package serial_add_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } req_state_t;

    typedef struct packed {
        logic [WIDTH_DEFAULT-1:0] a;
        logic [WIDTH_DEFAULT-1:0] b;
    } operand_pair_t;

endpackage

// File: rtl/serial_add_requester_sync_fifo.sv
// sync_fifo
// Single-clock FIFO storing any packed entry type (an operand pair by
// default). The head entry is presented combinationally on pop_data.
//   clk, rst_n : clock and asynchronous active-low reset
//   push       : write push_data this cycle (ignored when full)
//   push_data  : entry to store
//   pop        : remove the head entry this cycle (ignored when empty)
//   pop_data   : current head entry
//   full       : no free entries
//   empty      : no stored entries
//   count      : current occupancy, 0..DEPTH
module sync_fifo
    import serial_add_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = operand_pair_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array carries no reset; only the pointers and count define
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    // A simultaneous push and pop leaves the occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_add_requester.sv
// serial_add_requester
// Initiator for the bit-serial adder: queues operand pairs, issues one at
// a time over valid/ready, captures each result, checks it against the
// expected wrapped sum and forwards it downstream.
//   clk, rst_n          : clock and asynchronous active-low reset
//   push_valid/a/b      : upstream operand pair offer
//   push_ready          : operand FIFO not full
//   add_valid/a/b       : request to the adder (held until add_ready)
//   add_ready           : adder accepts the request
//   add_y, add_y_valid  : adder result
//   res_valid/res_y     : one-cycle result strobe and captured result
//   res_err             : result differs from (a+b) mod 2^WIDTH
//   timeout_err         : sticky watchdog flag
//   busy                : FIFO non-empty or an operation in flight
//   fifo_count          : operand FIFO occupancy
module serial_add_requester
    import serial_add_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_valid,
    input  logic [WIDTH-1:0]       push_a,
    input  logic [WIDTH-1:0]       push_b,
    output logic                   push_ready,
    output logic                   add_valid,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    input  logic                   add_ready,
    input  logic [WIDTH-1:0]       add_y,
    input  logic                   add_y_valid,
    output logic                   res_valid,
    output logic [WIDTH-1:0]       res_y,
    output logic                   res_err,
    output logic                   timeout_err,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    req_state_t       state;
    req_state_t       next_state;
    pair_t            push_pair;
    pair_t            head_pair;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;
    logic [WIDTH-1:0] exp_sum;
    logic [WD_W-1:0]  watchdog;
    logic             load_pair;
    logic             capture;
    logic             watchdog_expired;

    assign push_pair.a = push_a;
    assign push_pair.b = push_b;
    assign push_ready  = !fifo_full;
    assign exp_sum     = exp_a + exp_b;
    assign add_a       = exp_a;
    assign add_b       = exp_b;
    assign add_valid   = (state == ISSUE);
    assign busy        = (fifo_count != '0) || (state != IDLE);

    sync_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (pair_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_valid),
        .push_data (push_pair),
        .pop       (load_pair),
        .pop_data  (head_pair),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode. add_valid comes straight from the
    // state register, so add_ready never reaches it combinationally. A
    // result and the next pop may happen in the same cycle.
    always_comb begin
        next_state       = state;
        load_pair        = 1'b0;
        capture          = 1'b0;
        watchdog_expired = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    load_pair  = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (add_ready) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (add_y_valid) begin
                    capture = 1'b1;
                    if (!fifo_empty) begin
                        load_pair  = 1'b1;
                        next_state = ISSUE;
                    end else begin
                        next_state = IDLE;
                    end
                end else if (watchdog == WD_LAST) begin
                    watchdog_expired = 1'b1;
                    next_state       = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Watchdog counts WAIT cycles; it is cleared while the request is
    // still being offered so each operation starts counting from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            watchdog <= '0;
        end else if (state == ISSUE) begin
            watchdog <= '0;
        end else if (state == WAIT) begin
            watchdog <= watchdog + 1'b1;
        end
    end

    // In-flight operand registers, result capture and the sticky timeout
    // flag. The error compare uses the pair that was in flight, even when
    // the next pair is loaded on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_a       <= '0;
            exp_b       <= '0;
            res_valid   <= 1'b0;
            res_y       <= '0;
            res_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            res_valid <= capture;
            if (load_pair) begin
                exp_a <= head_pair.a;
                exp_b <= head_pair.b;
            end
            if (capture) begin
                res_y   <= add_y;
                res_err <= (add_y != exp_sum);
            end
            if (watchdog_expired) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_requester.sv
// tb_serial_add_requester
// Self-checking bench for serial_add_requester: a behavioural adder
// responder, a result monitor, table-driven single-pair vectors, directed
// multi-cycle sequences and a randomized phase scored against queues.
module tb_serial_add_requester;

    localparam int WIDTH   = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 32;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } pair_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y;
        logic       err;
    } exp_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] ret;
        logic [3:0] exp_y;
        logic       exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push_valid;
    logic [3:0] push_a;
    logic [3:0] push_b;
    logic       push_ready;
    logic       add_valid;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_ready;
    logic [3:0] add_y;
    logic       add_y_valid;
    logic       res_valid;
    logic [3:0] res_y;
    logic       res_err;
    logic       timeout_err;
    logic       busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int failures = 0;

    int         ready_mode = 0;
    int         lat_max = 0;
    bit         never_respond = 1'b0;
    int         inject_req = 0;
    logic [3:0] plan_q [$];
    pair_t      issued_q [$];
    int         hs_count = 0;
    int         overlap_errs = 0;

    logic [3:0] got_y_q [$];
    logic       got_err_q [$];

    int   got_rd = 0;
    int   issued_rd = 0;
    exp_t exp_q [$];

    serial_add_requester #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_valid  (push_valid),
        .push_a      (push_a),
        .push_b      (push_b),
        .push_ready  (push_ready),
        .add_valid   (add_valid),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_ready   (add_ready),
        .add_y       (add_y),
        .add_y_valid (add_y_valid),
        .res_valid   (res_valid),
        .res_y       (res_y),
        .res_err     (res_err),
        .timeout_err (timeout_err),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Behavioural adder: samples the handshake at the falling edge, then
    // answers after a random latency with either the planned value or the
    // true wrapped sum. It can also stay silent or emit a stray result.
    initial begin : adder_model
        bit         hs;
        bit         pend;
        int         lat;
        int         inject_done;
        int         plan_rd;
        logic [3:0] ha;
        logic [3:0] hb;
        logic [3:0] yv;
        pend        = 1'b0;
        lat         = 0;
        inject_done = 0;
        plan_rd     = 0;
        yv          = '0;
        add_ready   = 1'b0;
        add_y_valid = 1'b0;
        add_y       = '0;
        forever begin
            @(negedge clk);
            hs = rst_n && add_valid && add_ready;
            ha = add_a;
            hb = add_b;
            @(posedge clk);
            #1;
            add_y_valid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end
            if (hs) begin
                if (pend) begin
                    overlap_errs++;
                end
                hs_count++;
                issued_q.push_back({ha, hb});
                pend = !never_respond;
                lat  = (lat_max > 0) ? int'($urandom_range(lat_max, 0)) : 0;
                if (plan_rd < plan_q.size()) begin
                    yv = plan_q[plan_rd];
                    plan_rd++;
                end else begin
                    yv = ha + hb;
                end
            end
            if (pend) begin
                if (lat == 0) begin
                    add_y_valid = 1'b1;
                    add_y       = yv;
                    pend        = 1'b0;
                end else begin
                    lat--;
                end
            end else if (inject_done != inject_req) begin
                add_y_valid = 1'b1;
                add_y       = 4'h5;
                inject_done++;
            end
            case (ready_mode)
                0:       add_ready = 1'b1;
                1:       add_ready = 1'b0;
                default: add_ready = 1'($urandom_range(1, 0));
            endcase
        end
    end

    // Result monitor: records every res_valid strobe.
    initial begin : result_monitor
        forever begin
            @(negedge clk);
            if (res_valid) begin
                got_y_q.push_back(res_y);
                got_err_q.push_back(res_err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
        push_a     = a;
        push_b     = b;
        push_valid = 1'b1;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic waitAddValid(input string name, input int budget);
        int n = 0;
        while (!add_valid && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, 32'(add_valid), 32'd1);
    endtask

    task automatic waitHandshake(input string name, input int start, input int budget);
        int n = 0;
        while (hs_count == start && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, 32'(hs_count), 32'(start + 1));
    endtask

    task automatic drainAndCheck(input string name, input int budget);
        int   waited = 0;
        exp_t e;
        while ((got_y_q.size() - got_rd) < exp_q.size() && waited < budget) begin
            tick();
            waited++;
        end
        checkOutput({name, "_res_count"}, 32'(got_y_q.size() - got_rd), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_rd < got_y_q.size()) begin
                checkOutput({name, "_res_y"}, 32'(got_y_q[got_rd]), 32'(e.y));
                checkOutput({name, "_res_err"}, 32'(got_err_q[got_rd]), 32'(e.err));
                got_rd++;
            end
            if (issued_rd < issued_q.size()) begin
                checkOutput({name, "_issued"}, 32'(issued_q[issued_rd]), 32'({e.a, e.b}));
                issued_rd++;
            end else begin
                checkOutput({name, "_issued_count"}, 32'(issued_q.size()), 32'(issued_rd + 1));
            end
        end
        repeat (4) tick();
        checkOutput({name, "_extra_res"}, 32'(got_y_q.size()), 32'(got_rd));
        checkOutput({name, "_extra_issue"}, 32'(issued_q.size()), 32'(issued_rd));
    endtask

    // Main test sequence.
    initial begin : main
        vec_t       vectors [8];
        int         start;
        int         pushed_r;
        int         got_base;
        int         n;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] sum;
        logic [3:0] ret;

        vectors[0] = '{4'hA, 4'h4, 4'hE, 4'hE, 1'b0};
        vectors[1] = '{4'hA, 4'h8, 4'h2, 4'h2, 1'b0};
        vectors[2] = '{4'hF, 4'h1, 4'h0, 4'h0, 1'b0};
        vectors[3] = '{4'h3, 4'h3, 4'h7, 4'h7, 1'b1};
        vectors[4] = '{4'hF, 4'hF, 4'hE, 4'hE, 1'b0};
        vectors[5] = '{4'h5, 4'h6, 4'h0, 4'h0, 1'b1};
        vectors[6] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        vectors[7] = '{4'h9, 4'h7, 4'h1, 4'h1, 1'b1};

        push_valid = 1'b0;
        push_a     = '0;
        push_b     = '0;
        rst_n      = 1'b0;
        repeat (3) tick();

        checkOutput("rst_push_ready", 32'(push_ready), 32'd1);
        checkOutput("rst_add_valid", 32'(add_valid), 32'd0);
        checkOutput("rst_add_ab", 32'({add_a, add_b}), 32'd0);
        checkOutput("rst_res", 32'({res_valid, res_err, res_y}), 32'd0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);

        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            plan_q.push_back(vectors[i].ret);
            exp_q.push_back('{vectors[i].a, vectors[i].b, vectors[i].exp_y, vectors[i].exp_err});
            applyStimulus(vectors[i].a, vectors[i].b);
            drainAndCheck($sformatf("vec%0d", i), 60);
            checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
        end

        exp_q.push_back('{4'hA, 4'h4, 4'hE, 1'b0});
        exp_q.push_back('{4'h2, 4'h8, 4'hA, 1'b0});
        exp_q.push_back('{4'hF, 4'h1, 4'h0, 1'b0});
        applyStimulus(4'hA, 4'h4);
        applyStimulus(4'h2, 4'h8);
        applyStimulus(4'hF, 4'h1);
        drainAndCheck("b2b", 100);
        checkOutput("b2b_busy", 32'(busy), 32'd0);

        ready_mode = 1;
        start      = hs_count;
        exp_q.push_back('{4'h5, 4'h9, 4'hE, 1'b0});
        applyStimulus(4'h5, 4'h9);
        waitAddValid("bp_valid", 10);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("bp_hold%0d", i), 32'({add_valid, add_a, add_b}), 32'({1'b1, 4'h5, 4'h9}));
            tick();
        end
        checkOutput("bp_no_handshake", 32'(hs_count), 32'(start));
        ready_mode = 0;
        drainAndCheck("bp", 60);

        ready_mode = 1;
        exp_q.push_back('{4'h1, 4'h2, 4'h3, 1'b0});
        applyStimulus(4'h1, 4'h2);
        waitAddValid("full_first_valid", 10);
        for (int i = 0; i < DEPTH + 2; i++) begin
            ra = 4'(i + 3);
            rb = 4'hC;
            checkOutput($sformatf("full_push_ready%0d", i), 32'(push_ready), 32'(i < DEPTH));
            if (i < DEPTH) begin
                exp_q.push_back('{ra, rb, 4'(ra + rb), 1'b0});
            end
            applyStimulus(ra, rb);
        end
        checkOutput("full_fifo_count", 32'(fifo_count), 32'(DEPTH));
        checkOutput("full_push_ready", 32'(push_ready), 32'd0);
        checkOutput("full_busy", 32'(busy), 32'd1);
        ready_mode = 0;
        drainAndCheck("full", 200);

        never_respond = 1'b1;
        start         = hs_count;
        applyStimulus(4'hC, 4'h1);
        waitHandshake("to_handshake", start, 20);
        exp_q.push_back('{4'h6, 4'h7, 4'hD, 1'b0});
        applyStimulus(4'h6, 4'h7);
        repeat (TIMEOUT - 2) tick();
        checkOutput("to_not_yet", 32'(timeout_err), 32'd0);
        repeat (2) tick();
        checkOutput("to_flag", 32'(timeout_err), 32'd1);
        never_respond = 1'b0;
        checkOutput("to_no_result", 32'(got_y_q.size()), 32'(got_rd));
        if (issued_rd < issued_q.size()) begin
            checkOutput("to_dropped_pair", 32'(issued_q[issued_rd]), 32'({4'hC, 4'h1}));
            issued_rd++;
        end else begin
            checkOutput("to_dropped_issue", 32'(issued_q.size()), 32'(issued_rd + 1));
        end
        drainAndCheck("to_next", 100);
        checkOutput("to_sticky", 32'(timeout_err), 32'd1);

        never_respond = 1'b1;
        start         = hs_count;
        applyStimulus(4'h2, 4'h3);
        waitHandshake("rstw_handshake", start, 20);
        applyStimulus(4'h4, 4'h4);
        applyStimulus(4'h7, 4'h1);
        checkOutput("rstw_count_pre", 32'(fifo_count), 32'd2);
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("rstw_fifo_count", 32'(fifo_count), 32'd0);
        checkOutput("rstw_push_ready", 32'(push_ready), 32'd1);
        checkOutput("rstw_add_valid", 32'(add_valid), 32'd0);
        checkOutput("rstw_busy", 32'(busy), 32'd0);
        checkOutput("rstw_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("rstw_res_valid", 32'(res_valid), 32'd0);
        if (issued_rd < issued_q.size()) begin
            checkOutput("rstw_inflight_pair", 32'(issued_q[issued_rd]), 32'({4'h2, 4'h3}));
            issued_rd++;
        end else begin
            checkOutput("rstw_inflight_issue", 32'(issued_q.size()), 32'(issued_rd + 1));
        end
        tick();
        rst_n = 1'b1;
        tick();
        never_respond = 1'b0;
        inject_req++;
        repeat (5) tick();
        checkOutput("rstw_late_y", 32'(got_y_q.size()), 32'(got_rd));
        checkOutput("rstw_idle", 32'(busy), 32'd0);
        checkOutput("rstw_no_issue", 32'(issued_q.size()), 32'(issued_rd));

        ready_mode = 2;
        lat_max    = 3;
        pushed_r   = 0;
        got_base   = got_rd;
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(2, 0)) tick();
            n = 0;
            while ((pushed_r - (got_y_q.size() - got_base)) >= DEPTH && n < 200) begin
                tick();
                n++;
            end
            checkOutput("rand_push_ready", 32'(push_ready), 32'd1);
            ra  = 4'($urandom);
            rb  = 4'($urandom);
            sum = ra + rb;
            ret = sum;
            if ($urandom_range(3, 0) == 0) begin
                ret = sum ^ (4'h1 << $urandom_range(3, 0));
            end
            plan_q.push_back(ret);
            exp_q.push_back('{ra, rb, ret, (ret != sum)});
            applyStimulus(ra, rb);
            pushed_r++;
        end
        drainAndCheck("rand", 3000);

        checkOutput("no_overlap", 32'(overlap_errs), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
